fft8_s2p: RTL
=============

FFT8_S2P -- requirements
Module: fft8_s2p

Interface
REQ-001 SHALL have parameter DW, default 24, signed sample width of each real/imag component.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  serial sample present this cycle.
REQ-005 SHALL have port in_sof  input  1  start of frame; qualified by in_valid; marks sample 0.
REQ-006 SHALL have port in_real  input  DW  signed real part of serial sample.
REQ-007 SHALL have port in_imag  input  DW  signed imag part of serial sample.
REQ-008 SHALL have port en  output  1  one-cycle pulse; parallel frame on x*_ outputs is new; drives fft8 en.
REQ-009 SHALL have ports x0_real..x7_real, x0_imag..x7_imag  output  DW each  signed parallel frame, index k = k-th accepted sample of the frame.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on framing error.

Function
REQ-011 SHALL keep a 3-bit write index wr_idx and a collection buffer of 8 complex entries, separate from the output registers.
REQ-012 SHALL use two states: HUNT (wr_idx=0, waiting for sof) and FILL (wr_idx 1..7).
REQ-013 In HUNT, in_valid&in_sof SHALL write sample to entry 0, set wr_idx=1, go to FILL.
REQ-014 In HUNT, in_valid without in_sof SHALL drop the sample and pulse frame_err next cycle; state unchanged.
REQ-015 In FILL, in_valid without in_sof SHALL write entry wr_idx and increment wr_idx.
REQ-016 In FILL, in_valid&in_sof SHALL discard the partial frame, write the sample to entry 0, set wr_idx=1, stay in FILL, pulse frame_err next cycle.
REQ-017 Sample written to entry 7 SHALL complete the frame: same edge copies entries 0..6 plus the incoming sample into x0..x7, asserts en for exactly the following cycle, and returns to HUNT.
REQ-018 Latency SHALL be 1 cycle: en and new x* visible in the cycle after the edge accepting sample 7.
REQ-019 in_valid low SHALL stall; gaps of any length between samples SHALL not alter wr_idx or buffer contents.
REQ-020 x0..x7 SHALL hold their value between en pulses; collection of the next frame SHALL NOT change them.
REQ-021 Back-to-back frames at full rate (in_valid constantly high, sof every 8th sample) SHALL yield en every 8 cycles with no sample lost.
REQ-022 A sof arriving in the same cycle as sample 7 would be written is treated per REQ-016 (frame not completed, no en).
REQ-023 Data SHALL pass unmodified: no scaling, rounding or sign change; full DW bits preserved.
REQ-024 en and frame_err SHALL never assert in the same cycle.

Reset
REQ-025 While rstn=0: state HUNT, wr_idx=0, buffer entries 0, all x* = 0, en=0, frame_err=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame immediately; first sample after release requires in_sof.
REQ-027 First rising edge after rstn release SHALL be able to accept a sample.

Verification
REQ-028 Nominal: sof + samples real 10,20,30,40,10,20,30,40, imag 0, consecutive cycles -> one en pulse 1 cycle after last sample; x0..x7_real = 10..40 pattern, imag 0; chained fft8 gives y0_real=200, y2=(-40,+40), y4_real=-40, y6=(-40,-40), others 0.
REQ-029 Stalls: same frame with in_valid low 3 cycles between each sample -> identical x* values, single en, no frame_err.
REQ-030 Back-to-back: two frames (1..8 then -1..-8, imag = 100+k) with no gap -> en at cycle 9 and 17 after first sof; x* match each frame; first frame values stable cycles 9-16.
REQ-031 Resync: sof, 5 samples, sof, 8 samples -> frame_err pulse once, single en, x* equal the second frame; headless samples before any sof -> frame_err per sample, no en.
REQ-032 Reset mid-frame: rstn low after 4 samples, release, full frame -> all outputs 0 during reset, en only after full post-reset frame, x* equal post-reset data.
REQ-033 Extremes: samples -2^(DW-1) and 2^(DW-1)-1 -> appear bit-exact on x*.

Source files
------------

// File: rtl/fft8_s2p.sv
// rtl/fft8_s2p.sv - serial-to-parallel framer feeding an 8-point FFT
// Collects eight complex samples behind in_sof and presents them as one registered frame.
module fft8_s2p #(
  parameter int DW = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 en,
  output logic signed [DW-1:0] x0_real,
  output logic signed [DW-1:0] x1_real,
  output logic signed [DW-1:0] x2_real,
  output logic signed [DW-1:0] x3_real,
  output logic signed [DW-1:0] x4_real,
  output logic signed [DW-1:0] x5_real,
  output logic signed [DW-1:0] x6_real,
  output logic signed [DW-1:0] x7_real,
  output logic signed [DW-1:0] x0_imag,
  output logic signed [DW-1:0] x1_imag,
  output logic signed [DW-1:0] x2_imag,
  output logic signed [DW-1:0] x3_imag,
  output logic signed [DW-1:0] x4_imag,
  output logic signed [DW-1:0] x5_imag,
  output logic signed [DW-1:0] x6_imag,
  output logic signed [DW-1:0] x7_imag,
  output logic                 frame_err
);

  typedef enum logic {HUNT, FILL} state_t;

  state_t              state_q, state_d;
  logic [2:0]          wr_idx_q, wr_idx_d;
  logic                en_q, en_d;
  logic                err_q, err_d;
  logic signed [DW-1:0] buf_re_q [8];
  logic signed [DW-1:0] buf_re_d [8];
  logic signed [DW-1:0] buf_im_q [8];
  logic signed [DW-1:0] buf_im_d [8];
  logic signed [DW-1:0] x_re_q [8];
  logic signed [DW-1:0] x_re_d [8];
  logic signed [DW-1:0] x_im_q [8];
  logic signed [DW-1:0] x_im_d [8];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= HUNT;
      wr_idx_q <= '0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        buf_re_q[k] <= '0;
        buf_im_q[k] <= '0;
        x_re_q[k]   <= '0;
        x_im_q[k]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      en_q     <= en_d;
      err_q    <= err_d;
      for (int k = 0; k < 8; k++) begin
        buf_re_q[k] <= buf_re_d[k];
        buf_im_q[k] <= buf_im_d[k];
        x_re_q[k]   <= x_re_d[k];
        x_im_q[k]   <= x_im_d[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    en_d     = 1'b0;
    err_d    = 1'b0;
    buf_re_d = buf_re_q;
    buf_im_d = buf_im_q;
    x_re_d   = x_re_q;
    x_im_d   = x_im_q;

    if (in_valid) begin
      if (in_sof) begin
        // A sof always restarts collection; in FILL that abandons a partial frame.
        buf_re_d[0] = in_real;
        buf_im_d[0] = in_imag;
        wr_idx_d    = 3'd1;
        state_d     = FILL;
        err_d       = (state_q == FILL);
      end else if (state_q == HUNT) begin
        err_d = 1'b1;
      end else begin
        buf_re_d[wr_idx_q] = in_real;
        buf_im_d[wr_idx_q] = in_imag;
        if (wr_idx_q == 3'd7) begin
          for (int k = 0; k < 7; k++) begin
            x_re_d[k] = buf_re_q[k];
            x_im_d[k] = buf_im_q[k];
          end
          x_re_d[7] = in_real;
          x_im_d[7] = in_imag;
          en_d      = 1'b1;
          wr_idx_d  = 3'd0;
          state_d   = HUNT;
        end else begin
          wr_idx_d = wr_idx_q + 3'd1;
        end
      end
    end
  end

  assign en        = en_q;
  assign frame_err = err_q;

  assign x0_real = x_re_q[0];
  assign x1_real = x_re_q[1];
  assign x2_real = x_re_q[2];
  assign x3_real = x_re_q[3];
  assign x4_real = x_re_q[4];
  assign x5_real = x_re_q[5];
  assign x6_real = x_re_q[6];
  assign x7_real = x_re_q[7];
  assign x0_imag = x_im_q[0];
  assign x1_imag = x_im_q[1];
  assign x2_imag = x_im_q[2];
  assign x3_imag = x_im_q[3];
  assign x4_imag = x_im_q[4];
  assign x5_imag = x_im_q[5];
  assign x6_imag = x_im_q[6];
  assign x7_imag = x_im_q[7];

endmodule
